// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle logarithmic shift sequencer for the RV32 shift unit
module shift_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [XLEN-1:0]    req_a,
    input  logic [SHAMT_W-1:0] req_shamt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic [CNT_W-1:0]   ops_done
);

    localparam int K_W = $clog2(SHAMT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [K_W-1:0]     k;
    logic [XLEN-1:0]    data;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic [SHAMT_W-1:0] amt;
    logic [XLEN-1:0]    stage_out;
    logic               accept;

    assign req_ready = !flush && (state == IDLE || (state == DONE && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_data  = data;

    // One 2^k stage; right shifts OR in the latched fill bit over the vacated top bits.
    always_comb begin
        amt = SHAMT_W'(1) << k;
        if (op == 2'b00)
            stage_out = data << amt;
        else
            stage_out = (data >> amt) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> amt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            data      <= '0;
            op        <= '0;
            shamt     <= '0;
            fill      <= 1'b0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (state == DONE && rsp_ready) begin
                if (ops_done != '1)
                    ops_done <= ops_done + 1'b1;
                state     <= IDLE;
                rsp_valid <= 1'b0;
                busy      <= 1'b0;
            end
            if (state == SHIFT) begin
                if (shamt[k])
                    data <= stage_out;
                k <= k + 1'b1;
                if (k == K_W'(SHAMT_W - 1)) begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                end
            end
            // A new accept wins over the handshake's return to IDLE on the same edge.
            if (accept) begin
                op      <= req_op;
                shamt   <= req_shamt;
                data    <= req_a;
                k       <= '0;
                fill    <= (req_op == 2'b10) && req_a[XLEN-1];
                rsp_err <= (req_op == 2'b11);
                busy    <= 1'b1;
                if (req_shamt == '0 || req_op == 2'b11) begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                end else begin
                    state     <= SHIFT;
                    rsp_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.XLEN(32), .SHAMT_W(5), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word shift result plus a countdown to response, no stage model.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                              input logic [4:0] s);
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    logic        m_busy;
    logic [2:0]  m_cd;
    logic [31:0] m_res;
    logic        m_err;
    logic [15:0] m_cnt;
    logic        m_valid, m_hs, m_acc, m_rdy;

    assign m_valid = m_busy && (m_cd == 3'd0);
    assign m_hs    = m_valid && rsp_ready;
    assign m_rdy   = !flush && (!m_busy || m_hs);
    assign m_acc   = req_valid && m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cd   <= 3'd0;
            m_res  <= 32'd0;
            m_err  <= 1'b0;
            m_cnt  <= 16'd0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else begin
            if (m_hs && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
            if (m_acc) begin
                m_busy <= 1'b1;
                m_cd   <= (req_shamt == 5'd0 || req_op == 2'b11) ? 3'd0 : 3'd5;
                m_res  <= ref_shift(req_op, req_a, req_shamt);
                m_err  <= (req_op == 2'b11);
            end else if (m_hs) begin
                m_busy <= 1'b0;
            end else if (m_busy && m_cd != 3'd0) begin
                m_cd <= m_cd - 3'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, m_rdy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        chk("busy",      {31'd0, busy},      {31'd0, m_busy});
        chk("ops_done",  {16'd0, ops_done},  {16'd0, m_cnt});
        if (m_valid) begin
            chk("rsp_data", rsp_data, m_res);
            chk("rsp_err",  {31'd0, rsp_err}, {31'd0, m_err});
        end
    end

    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        int n = 0;
        req_op = o; req_a = a; req_shamt = s; req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_shamt = 5'($urandom);
    endtask

    task automatic wait_rsp(input string name, input int exp_lat,
                            input logic [31:0] exp_data, input logic exp_err);
        int lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_lat"},  lat, exp_lat);
        chk({name, "_data"}, rsp_data, exp_data);
        chk({name, "_err"},  {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 2'b00; req_a = 32'd0; req_shamt = 5'd0;
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_ops_done",  {16'd0, ops_done},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(2'b00, 32'h0000_0001, 5'd31);
        wait_rsp("sll31", 6, 32'h8000_0000, 1'b0);
        @(posedge clk); #1;
        chk("sll31_ops", {16'd0, ops_done}, 32'd1);

        // SRA then SRL back-to-back; second accept coincides with first handshake.
        req_op = 2'b10; req_a = 32'h8000_0000; req_shamt = 5'd4; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 2'b01;
        lat = 1;
        while (!req_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk("sra4_lat",   lat, 6);
        chk("sra4_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sra4_data",  rsp_data, 32'hF800_0000);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp("srl4", 6, 32'h0800_0000, 1'b0);
        @(posedge clk); #1;
        chk("b2b_ops", {16'd0, ops_done}, 32'd3);

        send(2'b01, 32'hDEAD_BEEF, 5'd0);
        wait_rsp("srl0", 1, 32'hDEAD_BEEF, 1'b0);
        send(2'b11, 32'h1234_5678, 5'd7);
        wait_rsp("ill", 1, 32'h1234_5678, 1'b1);
        @(posedge clk); #1;
        chk("ill_ops", {16'd0, ops_done}, 32'd5);

        rsp_ready = 1'b0;
        send(2'b00, 32'h0000_00F0, 5'd3);
        wait_rsp("bp", 6, 32'h0000_0780, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data",  rsp_data, 32'h0000_0780);
            chk("bp_err",   {31'd0, rsp_err}, 32'd0);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ops",   {16'd0, ops_done}, 32'd6);
        chk("bp_drop",  {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("bp_once",  {31'd0, rsp_valid}, 32'd0);

        send(2'b00, 32'h0000_0001, 5'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("flush_novalid", {31'd0, rsp_valid}, 32'd0);
        end
        chk("flush_ops", {16'd0, ops_done}, 32'd6);
        send(2'b00, 32'h0000_0003, 5'd2);
        wait_rsp("sll2", 6, 32'h0000_000C, 1'b0);
        @(posedge clk); #1;

        send(2'b00, 32'h0000_0005, 5'd9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy},      32'd0);
        chk("arst_ops",   {16'd0, ops_done},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stream shamt-0 requests until the counter saturates.
        rsp_ready = 1'b1;
        req_op = 2'b01; req_a = 32'hA5A5_5A5A; req_shamt = 5'd0; req_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("sat_ops", {16'd0, ops_done}, 32'h0000_FFFF);
        @(posedge clk); #1;
        send(2'b10, 32'h8000_0001, 5'd1);
        wait_rsp("sat_sra", 6, 32'hC000_0000, 1'b0);
        @(posedge clk); #1;
        chk("sat_hold", {16'd0, ops_done}, 32'h0000_FFFF);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
